simon_sequencer: RTL and testbench
==================================

# simon_sequencer

Game-round controller that sequences the 2-bit LFSR random source for the memory game. Each round it samples one new random step into a sequence buffer and plays the whole sequence out to the LED/tone driver with fixed on/gap timing. It then checks player button presses against the buffer, advancing, failing or winning the round. It sits between the LFSR (`rand_in`) and the display/button logic.

## Interface

- `MAX_LEN`, 16: maximum sequence length (1..255); reaching it ends the game in a win.
- `STEP_CYCLES`, 25_000_000: clock cycles each step is shown (`led_valid` high); must be ≥ 1.
- `GAP_CYCLES`, 12_500_000: clock cycles of dark gap after each shown step; must be ≥ 1.
- `LW`, derived, `$clog2(MAX_LEN+1)`: width of `level`.

Ports:

- `clk` in 1: system clock; everything is synchronous to its rising edge.
- `reset` in 1: asynchronous, active-high; forces the IDLE state and zeros all outputs.
- `start` in 1: single-cycle request to begin a new game.
- `rand_in` in 2: free-running LFSR output, sampled only in the ADD state.
- `btn_valid` in 1: single-cycle pulse marking a debounced player press.
- `btn_code` in 2: button index, valid while `btn_valid` is high.
- `led_valid` out 1: high while a step is being shown.
- `led_code` out 2: the step being shown; 0 when `led_valid` is low.
- `await_input` out 1: high while the block is waiting for player presses.
- `level` out LW: current sequence length (number of steps stored).
- `game_over` out 1: high in the FAIL state.
- `win` out 1: high in the WIN state.

## Operation

Registers:
- Sequence buffer: `seq[0..MAX_LEN-1]` × 2 bits.
- `len` (LW bits): current sequence length.
- `idx` (LW bits): current position in the sequence.
- Phase counter: wide enough for max(STEP_CYCLES, GAP_CYCLES).

The buffer is not cleared by reset. Only entries below `len` are ever read.

State behaviour:
- **IDLE**: all outputs 0. `start` clears `len` to 0 and moves to ADD.
- **ADD** (one cycle): `seq[len] <= rand_in`, `len <= len+1`, `idx <= 0`, counter cleared, then SHOW_ON.
- **SHOW_ON**: `led_valid=1`, `led_code=seq[idx]`. Stays exactly STEP_CYCLES cycles, then goes to SHOW_GAP with the counter cleared.
- **SHOW_GAP**: outputs dark. After exactly GAP_CYCLES cycles:
  - if `idx == len-1`: `idx <= 0`, go to WAIT_IN;
  - otherwise: `idx <= idx+1`, go to SHOW_ON.
- **WAIT_IN**: `await_input=1`. On `btn_valid`:
  - `btn_code != seq[idx]`: go to FAIL.
  - match and `idx < len-1`: `idx <= idx+1`.
  - match and `idx == len-1` and `len < MAX_LEN`: go to ADD.
  - match and `idx == len-1` and `len == MAX_LEN`: go to WIN.
- **FAIL**: `game_over=1`, `level` holds its value. `start` clears `len` and goes to ADD.
- **WIN**: `win=1`, `level = MAX_LEN`. `start` clears `len` and goes to ADD.

Input handling rules:
- `start` is ignored in ADD, SHOW_ON, SHOW_GAP and WAIT_IN; there is no mid-game restart.
- `btn_valid` is ignored outside WAIT_IN. Presses made during playback are dropped, not queued.
- No timeout in WAIT_IN; the block waits indefinitely.
- `level` reflects `len` at all times, so it increments in the cycle after ADD.

## Timing

- All outputs are registered Moore decodes of state/`len`; none depend combinationally on the inputs.
- Reset values: state IDLE, `len=0`, `idx=0`, counter 0, every output 0. Reset is asserted asynchronously and released synchronously by the integrating logic. Reset mid-playback or mid-input drops `led_valid` and `await_input` immediately.
- Game start, with `start` sampled at edge k:
  - state is ADD after edge k;
  - `led_valid` rises after edge k+1;
  - for round n, `await_input` rises after edge k+1+n·(STEP_CYCLES+GAP_CYCLES).
- Round advance: a correct final press sampled at edge m gives ADD after m. Playback restarts from `seq[0]` with `led_valid` high after edge m+1.
- A wrong press sampled at edge m: `await_input` low and `game_over` high after edge m.
- `btn_valid` held high for several cycles counts as several presses. Single-cycle pulses are the caller's responsibility.

## Test plan

Parameters for the bench: STEP_CYCLES=4, GAP_CYCLES=2, MAX_LEN=4.

- **Reset**: assert `reset` mid-SHOW_ON → all outputs 0 asynchronously; after release, `level=0` and state is IDLE.
- **First round**: hold `rand_in=2`, pulse `start` → `level=1`; `led_valid`/`led_code=2` for 4 cycles; 2 dark cycles; then `await_input=1`.
- **Correct replay**: with `seq={2}`, press 2 while `rand_in=1` → `level=2`; playback shows 2 then 1, each 4 on / 2 off; `await_input` rises 12 cycles after the ADD cycle.
- **Wrong press**: with `seq={2,1}`, press 2 then 3 → `game_over=1`, `level=2`, `await_input=0`; a later `start` → `level=1`, `game_over=0`.
- **Win boundary**: complete 4 correct rounds → `win=1`, `level=4`, no fifth ADD. Presses and `btn_valid` in WIN have no effect.
- **Ignored events**: pulse `start` and `btn_valid` during SHOW_ON/SHOW_GAP → playback timing, `level` and `idx` are unchanged.

Source files
------------

// File: rtl/simon_sequencer.sv
// Memory-game round controller: grows a random step sequence one entry per
// round, plays it out with fixed on/gap timing, then checks player presses.
module simon_sequencer #(
  parameter int unsigned MaxLen     = 16,
  parameter int unsigned StepCycles = 25_000_000,
  parameter int unsigned GapCycles  = 12_500_000,
  localparam int unsigned Lw        = $clog2(MaxLen + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [1:0]    rand_in_i,
  input  logic          btn_valid_i,
  input  logic [1:0]    btn_code_i,
  output logic          led_valid_o,
  output logic [1:0]    led_code_o,
  output logic          await_input_o,
  output logic [Lw-1:0] level_o,
  output logic          game_over_o,
  output logic          win_o
);

  localparam int unsigned MaxCyc = (StepCycles > GapCycles) ? StepCycles : GapCycles;
  localparam int unsigned Cw     = $clog2(MaxCyc + 1);
  // Buffer index width; len/idx carry one extra bit to represent MaxLen itself.
  localparam int unsigned Iw     = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  typedef enum logic [2:0] {
    StIdle, StAdd, StShowOn, StShowGap, StWaitIn, StFail, StWin
  } state_e;

  state_e        state_q, state_d;
  logic [Lw-1:0] len_q, len_d;
  logic [Lw-1:0] idx_q, idx_d;
  logic [Cw-1:0] cnt_q, cnt_d;
  logic          seq_we;
  logic [1:0]    seq_q [MaxLen];
  logic [1:0]    cur_step;
  logic          last_step;

  assign cur_step  = seq_q[idx_q[Iw-1:0]];
  assign last_step = (idx_q == len_q - Lw'(1));

  // State, length, position and phase-counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequence buffer; deliberately not reset, only entries below len are read.
  always_ff @(posedge clk_i) begin
    if (seq_we) begin
      seq_q[len_q[Iw-1:0]] <= rand_in_i;
    end
  end

  // Next-state logic for the round FSM.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seq_we  = 1'b0;
    unique case (state_q)
      StIdle, StFail, StWin: begin
        if (start_i) begin
          len_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        seq_we  = 1'b1;
        len_d   = len_q + Lw'(1);
        idx_d   = '0;
        cnt_d   = '0;
        state_d = StShowOn;
      end
      StShowOn: begin
        if (cnt_q == Cw'(StepCycles - 1)) begin
          cnt_d   = '0;
          state_d = StShowGap;
        end else begin
          cnt_d = cnt_q + Cw'(1);
        end
      end
      StShowGap: begin
        if (cnt_q == Cw'(GapCycles - 1)) begin
          cnt_d = '0;
          if (last_step) begin
            idx_d   = '0;
            state_d = StWaitIn;
          end else begin
            idx_d   = idx_q + Lw'(1);
            state_d = StShowOn;
          end
        end else begin
          cnt_d = cnt_q + Cw'(1);
        end
      end
      StWaitIn: begin
        if (btn_valid_i) begin
          if (btn_code_i != cur_step) begin
            state_d = StFail;
          end else if (!last_step) begin
            idx_d = idx_q + Lw'(1);
          end else if (len_q == Lw'(MaxLen)) begin
            state_d = StWin;
          end else begin
            state_d = StAdd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore output decode of the registered state and length.
  always_comb begin
    led_valid_o   = (state_q == StShowOn);
    led_code_o    = (state_q == StShowOn) ? cur_step : 2'd0;
    await_input_o = (state_q == StWaitIn);
    level_o       = len_q;
    game_over_o   = (state_q == StFail);
    win_o         = (state_q == StWin);
  end

endmodule

// File: tb/tb_simon_sequencer.sv
// Scoreboard bench for simon_sequencer: expected playback steps are queued as
// rounds start and popped as the DUT shows each step.
module tb_simon_sequencer;

  localparam int unsigned MaxLen     = 4;
  localparam int unsigned StepCycles = 4;
  localparam int unsigned GapCycles  = 2;
  localparam int unsigned Lw         = $clog2(MaxLen + 1);
  localparam int          RoundCyc   = StepCycles + GapCycles;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    rand_in = 2'd0;
  logic          btn_valid = 1'b0;
  logic [1:0]    btn_code = 2'd0;
  logic          led_valid;
  logic [1:0]    led_code;
  logic          await_input;
  logic [Lw-1:0] level;
  logic          game_over;
  logic          win;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] exp_q [$];  // steps the DUT still has to show
  logic [1:0] seq_m [$];  // sequence the player is expected to repeat

  simon_sequencer #(
    .MaxLen    (MaxLen),
    .StepCycles(StepCycles),
    .GapCycles (GapCycles)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .rand_in_i    (rand_in),
    .btn_valid_i  (btn_valid),
    .btn_code_i   (btn_code),
    .led_valid_o  (led_valid),
    .led_code_o   (led_code),
    .await_input_o(await_input),
    .level_o      (level),
    .game_over_o  (game_over),
    .win_o        (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Playback monitor: each lit run must be StepCycles long with the queued code.
  initial begin
    bit         in_run = 1'b0;
    int         run_len = 0;
    logic [1:0] run_code = 2'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_run  = 1'b0;
        run_len = 0;
      end else if (led_valid) begin
        if (!in_run) begin
          in_run   = 1'b1;
          run_len  = 0;
          run_code = led_code;
        end
        if (led_code != run_code) check("led_code_stable", led_code, run_code);
        run_len++;
      end else begin
        check("led_code_dark", led_code, 0);
        if (in_run) begin
          in_run = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_step", 1, 0);
          end else begin
            check("step_code", run_code, exp_q.pop_front());
            check("step_len", run_len, StepCycles);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [1:0] code);
    btn_valid = 1'b1;
    btn_code  = code;
    tick();
    btn_valid = 1'b0;
  endtask

  // Called just after the edge that entered ADD; rand_in must still hold r.
  task automatic new_round(input logic [1:0] r, input bit noise, input string tag);
    int cyc = 0;
    seq_m.push_back(r);
    foreach (seq_m[i]) exp_q.push_back(seq_m[i]);
    while (!await_input && cyc < 400) begin
      if (cyc == 1) begin
        check({tag, "_led_rise"}, led_valid, 1);
        check({tag, "_level"}, level, seq_m.size());
      end
      if (noise && (cyc == 3 || cyc == 6 || cyc == 8)) begin
        start     = 1'b1;
        btn_valid = 1'b1;
        btn_code  = ~seq_m[0];
      end
      tick();
      start     = 1'b0;
      btn_valid = 1'b0;
      cyc++;
    end
    check({tag, "_await_cycles"}, cyc, 1 + RoundCyc * seq_m.size());
    check({tag, "_level_wait"}, level, seq_m.size());
  endtask

  // Repeat the stored sequence; the final press lands the DUT in ADD or WIN.
  task automatic replay();
    for (int i = 0; i < seq_m.size(); i++) begin
      press(seq_m[i]);
      if (i < seq_m.size() - 1) check("replay_await", await_input, 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_led_valid", led_valid, 0);
    check("rst_await", await_input, 0);
    check("rst_level", level, 0);
    check("rst_game_over", game_over, 0);
    check("rst_win", win, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // First round
    rand_in = 2'd2;
    pulse_start();
    check("add_level", level, 0);
    check("add_led_valid", led_valid, 0);
    new_round(2'd2, 1'b0, "r1");

    // Correct replay grows the sequence to {2,1}
    rand_in = 2'd1;
    replay();
    new_round(2'd1, 1'b0, "r2");

    // Wrong press
    press(2'd2);
    check("wrong_await_mid", await_input, 1);
    press(2'd3);
    check("wrong_await", await_input, 0);
    check("wrong_game_over", game_over, 1);
    check("wrong_level", level, 2);
    press(2'd1);
    repeat (3) tick();
    check("fail_hold_game_over", game_over, 1);
    check("fail_hold_level", level, 2);

    // Restart from FAIL, then play to the win boundary
    rand_in = 2'd3;
    seq_m.delete();
    pulse_start();
    check("restart_level", level, 0);
    check("restart_game_over", game_over, 0);
    new_round(2'd3, 1'b0, "g2r1");
    rand_in = 2'd0;
    replay();
    new_round(2'd0, 1'b0, "g2r2");
    rand_in = 2'd1;
    replay();
    new_round(2'd1, 1'b1, "g2r3_noise");
    rand_in = 2'd2;
    replay();
    new_round(2'd2, 1'b0, "g2r4");
    replay();
    check("win", win, 1);
    check("win_level", level, MaxLen);
    check("win_await", await_input, 0);
    press(2'd0);
    press(2'd1);
    repeat (20) tick();
    check("win_hold", win, 1);
    check("win_hold_level", level, MaxLen);
    check("win_no_add_led", led_valid, 0);
    check("win_hold_await", await_input, 0);

    // Asynchronous reset mid-SHOW_ON
    rand_in = 2'd2;
    seq_m.delete();
    pulse_start();
    seq_m.push_back(2'd2);
    exp_q.push_back(2'd2);
    repeat (3) tick();
    check("pre_rst_led_valid", led_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_led_valid", led_valid, 0);
    check("arst_led_code", led_code, 0);
    check("arst_level", level, 0);
    check("arst_win", win, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) tick();
    check("post_rst_level", level, 0);
    check("post_rst_led_valid", led_valid, 0);
    check("post_rst_await", await_input, 0);
    check("post_rst_game_over", game_over, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
